// File: rtl/lsu_misalign.sv
// rtl/lsu_misalign.sv - load/store sequencer in front of dm; splits misaligned accesses into byte beats
// Define LSU_MISALIGN_TRAP_EN to trap misaligned requests (resp_err) instead of splitting them.
module lsu_misalign #(
  parameter int STORE_ACK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_we,
  output logic [2:0]  dm_type,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  localparam logic [2:0] DM_WORD              = 3'b000;
  localparam logic [2:0] DM_HALFWORD          = 3'b001;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
  localparam logic [2:0] DM_BYTE              = 3'b011;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BEAT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Unknown type codes behave as WORD.
  function automatic logic [2:0] size_of(input logic [2:0] t);
    case (t)
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: size_of = 3'd2;
      DM_BYTE, DM_BYTE_UNSIGNED:         size_of = 3'd1;
      default:                           size_of = 3'd4;
    endcase
  endfunction

  function automatic logic is_mis(input logic [2:0] t, input logic [1:0] a);
    case (t)
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: is_mis = a[0];
      DM_BYTE, DM_BYTE_UNSIGNED:         is_mis = 1'b0;
      default:                           is_mis = (a != 2'b00);
    endcase
  endfunction

  logic [1:0]  state;
  logic [1:0]  beat;
  logic        lat_we;
  logic [2:0]  lat_type;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_mis;
  logic        lat_err;
  logic [31:0] asm_data;
  logic        last_beat;
  logic        trap_hit;
  logic [31:0] ext_data;

  assign last_beat = !lat_mis || ({1'b0, beat} == (size_of(lat_type) - 3'd1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hit = is_mis(req_type, req_addr[1:0]);
`else
  assign trap_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      beat      <= 2'd0;
      lat_we    <= 1'b0;
      lat_type  <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_mis   <= 1'b0;
      lat_err   <= 1'b0;
      asm_data  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_type  <= req_type;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_mis   <= is_mis(req_type, req_addr[1:0]);
            lat_err   <= trap_hit;
            beat      <= 2'd0;
            asm_data  <= 32'd0;
            state     <= trap_hit ? S_RESP : S_BEAT;
          end
        end
        S_BEAT: begin
          if (!lat_we) begin
            if (lat_mis) asm_data[{beat, 3'b000} +: 8] <= dm_dout[7:0];
            else         asm_data <= dm_dout;
          end
          if (last_beat) begin
            beat  <= 2'd0;
            state <= (lat_we && STORE_ACK == 0) ? S_IDLE : S_RESP;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ext_data = asm_data;
    case (lat_type)
      DM_HALFWORD:          ext_data = {{16{asm_data[15]}}, asm_data[15:0]};
      DM_HALFWORD_UNSIGNED: ext_data = {16'd0, asm_data[15:0]};
      DM_BYTE:              ext_data = {{24{asm_data[7]}}, asm_data[7:0]};
      DM_BYTE_UNSIGNED:     ext_data = {24'd0, asm_data[7:0]};
      default:              ext_data = asm_data;
    endcase
  end

  always_comb begin
    dm_we   = 1'b0;
    dm_type = DM_WORD;
    dm_addr = 32'd0;
    dm_din  = 32'd0;
    if (state == S_BEAT) begin
      dm_we = lat_we;
      if (lat_mis) begin
        dm_type = DM_BYTE;
        dm_addr = lat_addr + {30'd0, beat};
        dm_din  = {24'd0, lat_wdata[{beat, 3'b000} +: 8]};
      end else begin
        dm_type = lat_type;
        dm_addr = lat_addr;
        dm_din  = lat_wdata;
      end
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = (state == S_RESP && !lat_we && !lat_err) ? ext_data : 32'd0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign resp_err = (state == S_RESP) && lat_err;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_misalign.sv
// tb/tb_lsu_misalign.sv - randomized self-checking bench for lsu_misalign with a byte-array dm model
module tb_lsu_misalign;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_we;
  logic [2:0]  dm_type;
  logic [31:0] dm_addr, dm_din, dm_dout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_misalign #(.STORE_ACK(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_dout(dm_dout)
  );

  // dm model: 256 bytes, little-endian; out-of-range reads 0, writes dropped
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       init_we = 1'b0;
  logic [7:0] init_addr = 8'd0;
  logic [7:0] init_data = 8'd0;

  function automatic int size_of(input logic [2:0] t);
    if (t == DM_HALF || t == DM_HALFU) return 2;
    if (t == DM_BYTE || t == DM_BYTEU) return 1;
    return 4;
  endfunction

  function automatic logic [7:0] rd(input logic [31:0] a);
    return (a < 32'd256) ? mem[a[7:0]] : 8'h00;
  endfunction

  always_comb begin
    dm_dout = 32'd0;
    for (int i = 0; i < 4; i++)
      if (i < size_of(dm_type)) dm_dout[8*i +: 8] = rd(dm_addr + 32'(i));
  end

  always @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_data;
    else if (dm_we) begin
      for (int i = 0; i < 4; i++)
        if (i < size_of(dm_type) && (dm_addr + 32'(i)) < 32'd256)
          mem[8'(dm_addr + 32'(i))] <= dm_din[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_byte(input logic [7:0] a, input logic [7:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  task automatic set_word(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) set_byte(a + 8'(i), w[8*i +: 8]);
  endtask

  function automatic logic [31:0] ext(input logic [2:0] t, input logic [31:0] v);
    case (t)
      DM_HALF:  return {{16{v[15]}}, v[15:0]};
      DM_HALFU: return {16'd0, v[15:0]};
      DM_BYTE:  return {{24{v[7]}}, v[7:0]};
      DM_BYTEU: return {24'd0, v[7:0]};
      default:  return v;
    endcase
  endfunction

  task automatic run_txn(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
    int sz, nb, lat, beats, busy;
    logic m, trap, got;
    logic [31:0] v, exp_rd, ba;
    sz = size_of(t);
    m = (sz == 4) ? (a[1:0] != 2'b00) : (sz == 2) ? a[0] : 1'b0;
    trap = TRAP && m;
    nb = trap ? 0 : (m ? sz : 1);
    v = 32'd0;
    for (int i = 0; i < sz; i++) begin
      ba = a + 32'(i);
      v[8*i +: 8] = (ba < 32'd256) ? ref_mem[ba[7:0]] : 8'h00;
    end
    exp_rd = (!we && !trap) ? ext(t, v) : 32'd0;
    if (we && !trap)
      for (int i = 0; i < sz; i++) begin
        ba = a + 32'(i);
        if (ba < 32'd256) ref_mem[ba[7:0]] = wd[8*i +: 8];
      end

    @(negedge clk);
    req_we = we; req_type = t; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; beats = 0; busy = 0; got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (!req_ready) busy++;
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end else if (!req_ready) begin
        check("beat_addr", dm_addr, m ? a + 32'(beats) : a);
        check("beat_type", {29'd0, dm_type}, {29'd0, m ? DM_BYTE : t});
        check("beat_we", {31'd0, dm_we}, {31'd0, we});
        beats++;
      end
    end
    check("latency", lat, nb + 1);
    check("beats", beats, nb);
    check("busy", busy, nb + 1);
    check("rdata", resp_rdata, exp_rd);
    check("err", {31'd0, resp_err}, {31'd0, trap});
    @(negedge clk);
    check("pulse_end", {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    logic        saw;
    logic [31:0] w;
    int          diff;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_type = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outs", {resp_valid, resp_err, dm_we, dm_type}, 6'd0);
    check("rst_addr", dm_addr | dm_din | resp_rdata, 32'd0);
    for (int i = 0; i < 256; i++) set_byte(8'(i), 8'($urandom));
    @(negedge clk); rst = 1'b0;

    // aligned and sub-word loads
    set_word(8'h10, 32'h8899AABB);
    run_txn(1'b0, DM_WORD,  32'h10, 32'd0);
    run_txn(1'b0, DM_HALF,  32'h12, 32'd0);
    run_txn(1'b0, DM_HALFU, 32'h12, 32'd0);
    run_txn(1'b0, DM_BYTE,  32'h11, 32'd0);

    // misaligned word load across a word boundary
    set_word(8'h10, 32'h44332211);
    set_word(8'h14, 32'h88776655);
    run_txn(1'b0, DM_WORD, 32'h13, 32'd0);

    // misaligned halfword store
    set_word(8'h20, 32'd0);
    run_txn(1'b1, DM_HALF, 32'h21, 32'h0000BEEF);
    w = {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]};
    check("sh_result", w, TRAP ? 32'd0 : 32'h00BEEF00);

    // reset during beat 2 of a misaligned word store
    if (!TRAP) begin
      set_word(8'h30, 32'd0);
      set_byte(8'h34, 8'h5A);
      @(negedge clk);
      req_we = 1'b1; req_type = DM_WORD; req_addr = 32'h31; req_wdata = 32'hDDCCBBAA; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      check("abort_beat", dm_addr, 32'h33);
      rst = 1'b1;
      #1;
      check("abort_ready", {31'd0, req_ready}, 32'd1);
      check("abort_outs", {30'd0, dm_we, resp_valid}, 32'd0);
      check("abort_addr", dm_addr, 32'd0);
      @(negedge clk); rst = 1'b0;
      saw = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (resp_valid || !req_ready) saw = 1'b1;
      end
      check("abort_quiet", {31'd0, saw}, 32'd0);
      check("abort_mem", {mem[8'h34], mem[8'h33], mem[8'h32], mem[8'h31]}, 32'h5A00BBAA);
      ref_mem[8'h31] = 8'hAA;
      ref_mem[8'h32] = 8'hBB;
    end

    // randomized mix including unknown codes and address wrap
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = ($urandom % 8 == 0) ? 32'hFFFFFFFC + ($urandom % 4) : ($urandom % 252);
      run_txn(1'($urandom % 2), 3'($urandom % 8), a, $urandom);
    end

    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
    check("mem_image", diff, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
